// File: rtl/ring_monitor_if.sv
// Sample/status bundle between a ring-counter source and ring_monitor.
// err_cnt exists only when RING_MONITOR_ERRCNT_EN is defined.
interface ring_monitor_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned REV_W = 8
);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             in_vld;
  logic [N-1:0]     in_q;
  logic             clr;
  logic [IDX_W-1:0] idx;
  logic             idx_vld;
  logic             locked;
  logic             err_onehot;
  logic             err_step;
  logic             err_sticky;
  logic [REV_W-1:0] rev_cnt;
`ifdef RING_MONITOR_ERRCNT_EN
  logic [7:0]       err_cnt;

  modport master (
    output in_vld, in_q, clr,
    input  idx, idx_vld, locked, err_onehot, err_step, err_sticky, rev_cnt, err_cnt
  );
  modport slave (
    input  in_vld, in_q, clr,
    output idx, idx_vld, locked, err_onehot, err_step, err_sticky, rev_cnt, err_cnt
  );
`else
  modport master (
    output in_vld, in_q, clr,
    input  idx, idx_vld, locked, err_onehot, err_step, err_sticky, rev_cnt
  );
  modport slave (
    input  in_vld, in_q, clr,
    output idx, idx_vld, locked, err_onehot, err_step, err_sticky, rev_cnt
  );
`endif
endinterface

// File: rtl/ring_monitor.sv
// Checks a sampled one-hot ring counter: locks onto legal rotation, flags errors, counts revolutions.
// Optional saturating error counter enabled by RING_MONITOR_ERRCNT_EN.
module ring_monitor #(
  parameter int unsigned N     = 4,
  parameter int unsigned REV_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  ring_monitor_if.slave  bus
);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] TOP_BIT = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} state_t;

  state_t           r_state;
  logic [N-1:0]     r_prev;
  logic [IDX_W-1:0] r_idx;
  logic             r_idx_vld;
  logic             r_locked;
  logic             r_err_onehot;
  logic             r_err_step;
  logic             r_err_sticky;
  logic [REV_W-1:0] r_rev_cnt;

  logic             w_onehot;
  logic             w_match;
  logic             w_accept;
  logic             w_err_oh;
  logic             w_err_step;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_idx;

  assign w_onehot   = $onehot(bus.in_q);
  assign w_rot      = {r_prev[0], r_prev[N-1:1]};
  assign w_match    = w_onehot && (bus.in_q == w_rot);
  assign w_accept   = bus.in_vld && !bus.clr;
  // FAULT swallows everything, so only live states can raise a pulse
  assign w_err_oh   = w_accept && !w_onehot && (r_state != FAULT);
  assign w_err_step = w_accept && w_onehot && (r_state == LOCK) && !w_match;

  // Binary position of the hot bit
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.in_q[i]) w_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_idx        <= '0;
      r_idx_vld    <= 1'b0;
      r_locked     <= 1'b0;
      r_err_onehot <= 1'b0;
      r_err_step   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_rev_cnt    <= '0;
    end else begin
      r_err_onehot <= w_err_oh;
      r_err_step   <= w_err_step;
      r_idx_vld    <= w_accept && w_onehot;
      if (w_accept && w_onehot) r_idx <= w_idx;

      if (bus.clr) begin
        r_state      <= IDLE;
        r_prev       <= '0;
        r_locked     <= 1'b0;
        r_err_sticky <= 1'b0;
        r_rev_cnt    <= '0;
      end else if (bus.in_vld) begin
        case (r_state)
          IDLE: begin
            if (w_onehot) begin
              r_prev  <= bus.in_q;
              r_state <= ACQ;
            end
          end
          ACQ: begin
            if (w_match) begin
              r_prev   <= bus.in_q;
              r_state  <= LOCK;
              r_locked <= 1'b1;
            end else if (w_onehot) begin
              r_prev <= bus.in_q;
            end else begin
              r_state <= IDLE;
            end
          end
          LOCK: begin
            if (w_match) begin
              r_prev <= bus.in_q;
              if (bus.in_q == TOP_BIT) r_rev_cnt <= r_rev_cnt + REV_W'(1);
            end else begin
              r_state      <= FAULT;
              r_locked     <= 1'b0;
              r_err_sticky <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.idx        = r_idx;
  assign bus.idx_vld    = r_idx_vld;
  assign bus.locked     = r_locked;
  assign bus.err_onehot = r_err_onehot;
  assign bus.err_step   = r_err_step;
  assign bus.err_sticky = r_err_sticky;
  assign bus.rev_cnt    = r_rev_cnt;

`ifdef RING_MONITOR_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (bus.clr) begin
      r_err_cnt <= '0;
    end else if ((w_err_oh || w_err_step) && (r_err_cnt != 8'd255)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed pins plus randomized traffic against a behavioural model.
// Define RING_MONITOR_ERRCNT_EN to also exercise err_cnt.
module tb_ring_monitor;
  localparam int unsigned N     = 4;
  localparam int unsigned REV_W = 8;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ring_monitor_if #(.N(N), .REV_W(REV_W)) bus ();
  ring_monitor #(.N(N), .REV_W(REV_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model
  int m_mode, m_prev, m_idx, m_idx_vld, m_oh, m_step, m_sticky, m_rev, m_ecnt, m_locked;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int rot_of(input int p);
    return (p == 1) ? (1 << (N - 1)) : (p >> 1);
  endfunction

  function automatic int pos_of(input int q);
    int r = 0;
    for (int i = 0; i < int'(N); i++) if (q == (1 << i)) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_prev = 0; m_idx = 0; m_idx_vld = 0; m_oh = 0; m_step = 0;
    m_sticky = 0; m_rev = 0; m_ecnt = 0; m_locked = 0;
  endtask

  task automatic model_step(input int v, input int q, input int c);
    bit oh;
    oh = ($countones(q) == 1);
    m_oh = 0; m_step = 0;
    m_idx_vld = (v != 0 && oh && c == 0) ? 1 : 0;
    if (m_idx_vld == 1) m_idx = pos_of(q);
    if (c != 0) begin
      m_mode = M_IDLE; m_prev = 0; m_sticky = 0; m_rev = 0; m_ecnt = 0;
    end else if (v != 0) begin
      if (m_mode == M_IDLE) begin
        if (oh) begin m_prev = q; m_mode = M_ACQ; end
        else m_oh = 1;
      end else if (m_mode == M_ACQ) begin
        if (oh && q == rot_of(m_prev)) begin m_prev = q; m_mode = M_LOCK; end
        else if (oh) m_prev = q;
        else begin m_oh = 1; m_mode = M_IDLE; end
      end else if (m_mode == M_LOCK) begin
        if (oh && q == rot_of(m_prev)) begin
          m_prev = q;
          if (q == (1 << (N - 1))) m_rev = (m_rev + 1) % (1 << REV_W);
        end else begin
          if (oh) m_step = 1; else m_oh = 1;
          m_sticky = 1; m_mode = M_FAULT;
        end
      end
      if ((m_oh + m_step) != 0 && m_ecnt < 255) m_ecnt++;
    end
    m_locked = (m_mode == M_LOCK) ? 1 : 0;
  endtask

  task automatic cmp_all();
    chk("idx", int'(bus.idx), m_idx);
    chk("idx_vld", int'(bus.idx_vld), m_idx_vld);
    chk("locked", int'(bus.locked), m_locked);
    chk("err_onehot", int'(bus.err_onehot), m_oh);
    chk("err_step", int'(bus.err_step), m_step);
    chk("err_sticky", int'(bus.err_sticky), m_sticky);
    chk("rev_cnt", int'(bus.rev_cnt), m_rev);
    chk("err_exclusive", int'(bus.err_onehot & bus.err_step), 0);
`ifdef RING_MONITOR_ERRCNT_EN
    chk("err_cnt", int'(bus.err_cnt), m_ecnt);
`endif
  endtask

  // One sample: drive, clock, update model, check #1 after the edge
  task automatic cycle(input int v, input int q, input int c);
    bus.in_vld = 1'(v);
    bus.in_q   = N'(q);
    bus.clr    = 1'(c);
    @(posedge clk);
    if (rst) model_reset(); else model_step(v, q, c);
    #1;
    cmp_all();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_idx"}, int'(bus.idx), 0);
    chk({tag, "_idx_vld"}, int'(bus.idx_vld), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_err_onehot"}, int'(bus.err_onehot), 0);
    chk({tag, "_err_step"}, int'(bus.err_step), 0);
    chk({tag, "_err_sticky"}, int'(bus.err_sticky), 0);
    chk({tag, "_rev_cnt"}, int'(bus.rev_cnt), 0);
`ifdef RING_MONITOR_ERRCNT_EN
    chk({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
`endif
  endtask

  initial begin
    int seq[5]   = '{8, 4, 2, 1, 8};
    int e_idx[5] = '{3, 2, 1, 0, 3};
    int e_lck[5] = '{0, 1, 1, 1, 1};
    int e_rev[5] = '{0, 0, 0, 0, 1};
    int v, q, c, r;

    bus.in_vld = 1'b0; bus.in_q = '0; bus.clr = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    cycle(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic lock sequence, pinned with literals
    for (int i = 0; i < 5; i++) begin
      cycle(1, seq[i], 0);
      chk("pin_idx", int'(bus.idx), e_idx[i]);
      chk("pin_locked", int'(bus.locked), e_lck[i]);
      chk("pin_rev", int'(bus.rev_cnt), e_rev[i]);
    end
    // gap while locked, then multi-hot
    cycle(0, 6, 0);
    chk("pin_gap_locked", int'(bus.locked), 1);
    cycle(1, 4, 0);
    cycle(1, 6, 0);
    chk("pin_multihot_pulse", int'(bus.err_onehot), 1);
    chk("pin_multihot_sticky", int'(bus.err_sticky), 1);
    chk("pin_multihot_locked", int'(bus.locked), 0);
    cycle(1, 3, 0);
    chk("pin_fault_quiet", int'(bus.err_onehot), 0);
    cycle(0, 0, 1);
    chk("pin_clr_sticky", int'(bus.err_sticky), 0);
    chk("pin_clr_rev", int'(bus.rev_cnt), 0);

    // repeat of prev while locked
    cycle(1, 8, 0); cycle(1, 4, 0); cycle(1, 4, 0);
    chk("pin_repeat_step", int'(bus.err_step), 1);
    chk("pin_repeat_sticky", int'(bus.err_sticky), 1);
    cycle(0, 0, 1);

    // all-zero in IDLE, then clr with illegal sample
    cycle(1, 0, 0);
    chk("pin_zero_pulse", int'(bus.err_onehot), 1);
    chk("pin_zero_sticky", int'(bus.err_sticky), 0);
    cycle(1, 15, 1);
    chk("pin_clr_prio", int'(bus.err_onehot), 0);
    // ACQ mismatch reacquires without error
    cycle(1, 8, 0); cycle(1, 2, 0); cycle(1, 1, 0);
    chk("pin_acq_relock", int'(bus.locked), 1);

    // long legal run wraps rev_cnt
    for (int i = 0; i < 1100; i++) cycle(1, rot_of(m_prev), 0);
    cycle(0, 0, 1);

`ifdef RING_MONITOR_ERRCNT_EN
    for (int i = 0; i < 300; i++) cycle(1, 5, 0);
    chk("pin_errcnt_sat", int'(bus.err_cnt), 255);
`endif

    // asynchronous reset mid-run
    cycle(1, 8, 0); cycle(1, 4, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    cycle(1, 2, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 1, 0);
    chk("pin_post_rst_unlocked", int'(bus.locked), 0);
    cycle(1, 8, 0);
    chk("pin_post_rst_relock", int'(bus.locked), 1);

    // randomized traffic, biased toward legal rotation
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      v = (r < 85) ? 1 : 0;
      c = ($urandom_range(99) < 3) ? 1 : 0;
      r = int'($urandom_range(99));
      if (r < 75 && m_prev != 0) q = rot_of(m_prev);
      else if (r < 88) q = 1 << $urandom_range(N - 1);
      else q = int'($urandom_range((1 << N) - 1));
      cycle(v, q, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ring_monitor.md
RING_MONITOR -- requirements
Module: ring_monitor

Interface
REQ-001 Parameter N, default 4: ring width in bits; legal range 2..16.
REQ-002 Parameter REV_W, default 8: revolution counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_vld  input  1  in_q sample is valid this cycle.
REQ-006 in_q  input  N  sampled ring-counter state under check.
REQ-007 clr  input  1  synchronous clear: FSM, sticky error, counters.
REQ-008 idx  output  clog2(N)  binary position of the hot bit in the last one-hot sample.
REQ-009 idx_vld  output  1  idx updated this cycle.
REQ-010 locked  output  1  high while the FSM is in LOCK.
REQ-011 err_onehot  output  1  one-cycle pulse: a valid sample was not one-hot.
REQ-012 err_step  output  1  one-cycle pulse: one-hot sample in LOCK violated the rotation rule.
REQ-013 err_sticky  output  1  set on any error in LOCK; held until clr or rst.
REQ-014 rev_cnt  output  REV_W  completed revolutions while locked.

Function
REQ-015 Legal successor SHALL be rot(p) = {p[0], p[N-1:1]}, i.e. hot bit moves one position down, bit 0 wraps to bit N-1 (1000->0100->0010->0001->1000 for N=4).
REQ-016 One-hot check SHALL be exactly one bit set; all-zero and multi-hot are errors.
REQ-017 All outputs SHALL be registered; response to a sample at edge k appears after edge k+1 (latency 1).
REQ-018 idx_vld SHALL equal the registered value of (in_vld & one-hot & !clr); idx holds its previous value otherwise.
REQ-019 The monitor SHALL store the last accepted one-hot sample as prev.
REQ-020 FSM states: IDLE, ACQ, LOCK, FAULT.
REQ-021 IDLE: valid one-hot -> store prev, go ACQ; valid non-one-hot -> err_onehot pulse, stay IDLE; no sticky set.
REQ-022 ACQ: valid in_q == rot(prev) -> LOCK; valid one-hot mismatch -> store new prev, stay ACQ, no error; valid non-one-hot -> err_onehot pulse, go IDLE.
REQ-023 LOCK: valid in_q == rot(prev) -> stay, update prev; valid one-hot mismatch (including repeat of prev) -> err_step pulse, err_sticky=1, go FAULT; valid non-one-hot -> err_onehot pulse, err_sticky=1, go FAULT.
REQ-024 FAULT: SHALL ignore samples and flag no further errors; exits only via clr (to IDLE) or rst.
REQ-025 rev_cnt SHALL increment when a legal step in LOCK lands on in_q with only bit N-1 set; wraps modulo 2^REV_W.
REQ-026 Cycles with in_vld=0 SHALL not change FSM state, prev, or counters.
REQ-027 clr SHALL take priority over a simultaneous in_vld: sample discarded, FSM -> IDLE, err_sticky=0, rev_cnt=0, no error pulse.
REQ-028 err_onehot and err_step SHALL never assert in the same cycle.

Reset
REQ-029 On rst: FSM=IDLE, prev=0, idx=0, idx_vld=0, locked=0, err_onehot=0, err_step=0, err_sticky=0, rev_cnt=0 (and err_cnt=0 when present), immediately without waiting for clk.
REQ-030 rst asserted mid-operation SHALL discard lock state; reacquisition requires two consecutive legal samples after release.

Configuration
REQ-031 Macro RING_MONITOR_ERRCNT_EN defined: extra output err_cnt [7:0], counting every err_onehot and err_step pulse, saturating at 255, cleared by clr and rst.
REQ-032 Macro undefined: err_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 rst release, then in_q 1000,0100,0010,0001,1000 every cycle with in_vld=1 -> locked=1 from 2nd response, idx 3,2,1,0,3, rev_cnt=1, no errors.
REQ-034 Locked, then in_q=0110 -> err_onehot pulse one cycle, err_sticky=1, locked=0; later samples ignored; clr -> IDLE, err_sticky=0, rev_cnt=0.
REQ-035 Locked at 0100, next sample 0100 (repeat) -> err_step pulse, FAULT, err_sticky=1.
REQ-036 IDLE, in_q=0000 with in_vld -> err_onehot pulse, err_sticky stays 0, state IDLE; in_vld=0 gaps mid-LOCK -> no state change.
REQ-037 clr and in_vld=1 with illegal in_q in same cycle -> no error pulse, state IDLE, counters 0.
REQ-038 RING_MONITOR_ERRCNT_EN defined, 300 non-one-hot samples in IDLE -> err_cnt=255; rst mid-sequence -> all outputs zero asynchronously.
